// File: rtl/rr_arbiter_pkg.sv
// Shared defaults, index-width helper and transfer-kind enum for the rr_arbiter slice.
package rr_arbiter_pkg;

  localparam int ARB_N_REQ_DEF  = 4;
  localparam int ARB_DATA_W_DEF = 3;

  // Index width for n requesters; a 1-bit index is kept even for n <= 2.
  function automatic int arb_idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // What the output stage does on the coming edge.
  typedef enum logic [1:0] {
    XFER_IDLE  = 2'd0,
    XFER_LOAD  = 2'd1,
    XFER_DRAIN = 2'd2
  } xfer_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// rr_pick: combinational round-robin picker. Scans req starting at ptr, wrapping,
// via a double-width copy of req whose low half is masked below ptr.
module rr_pick
  import rr_arbiter_pkg::*;
#(
  parameter int N_REQ = ARB_N_REQ_DEF,
  parameter int IDX_W = arb_idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic [2*N_REQ-1:0] scan;
  logic               found;

  always_comb begin
    // NOTE: every output and temporary gets a default before any conditional
    // assignment, so no path through the block leaves a value held (no latch).
    scan    = {req, req};
    found   = 1'b0;
    gnt     = '0;
    gnt_idx = '0;

    for (int i = 0; i < N_REQ; i++) begin
      if (i < int'(ptr)) scan[i] = 1'b0;
    end

    // Upper copy supplies the wrapped-around part of the search.
    for (int k = 0; k < 2*N_REQ; k++) begin
      if (!found && scan[k]) begin
        found              = 1'b1;
        gnt[k % N_REQ]     = 1'b1;
        gnt_idx            = IDX_W'(k % N_REQ);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: N_REQ-to-1 valid/ready arbiter feeding a single-entry output stage.
// Define RR_ARBITER_FIXED_PRIO_EN for fixed lowest-index-first priority (no pointer).
module rr_arbiter
  import rr_arbiter_pkg::*;
#(
  parameter  int N_REQ  = ARB_N_REQ_DEF,
  parameter  int DATA_W = ARB_DATA_W_DEF,
  localparam int IDX_W  = arb_idx_w(N_REQ)
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic [N_REQ-1:0]         valid_up,
  input  logic [N_REQ*DATA_W-1:0]  data_up,
  output logic [N_REQ-1:0]         ready_up,
  output logic                     valid_down,
  output logic [DATA_W-1:0]        data_down,
  output logic [IDX_W-1:0]         src_down,
  input  logic                     ready_down
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q,  data_d;
  logic [IDX_W-1:0]  src_q,   src_d;
  logic [IDX_W-1:0]  scan_ptr;
  logic [N_REQ-1:0]  gnt;
  logic [IDX_W-1:0]  gnt_idx;
  logic              can_load;
  xfer_e             xfer;

`ifdef RR_ARBITER_FIXED_PRIO_EN
  assign scan_ptr = '0;
`else
  logic [IDX_W-1:0] ptr_q, ptr_d;
  assign scan_ptr = ptr_q;
`endif

  rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req     (valid_up),
    .ptr     (scan_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  always_comb begin
    can_load = !valid_q || ready_down;
    ready_up = (can_load && !sys_rst) ? gnt : '0;

    if (can_load && (|valid_up))     xfer = XFER_LOAD;
    else if (valid_q && ready_down)  xfer = XFER_DRAIN;
    else                             xfer = XFER_IDLE;

    valid_d = valid_q;
    data_d  = data_q;
    src_d   = src_q;
`ifndef RR_ARBITER_FIXED_PRIO_EN
    ptr_d   = ptr_q;
`endif

    case (xfer)
      XFER_LOAD: begin
        valid_d = 1'b1;
        data_d  = data_up[int'(gnt_idx)*DATA_W +: DATA_W];
        src_d   = gnt_idx;
`ifndef RR_ARBITER_FIXED_PRIO_EN
        ptr_d   = (gnt_idx == IDX_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
`endif
      end
      XFER_DRAIN: valid_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    if (sys_rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

`ifndef RR_ARBITER_FIXED_PRIO_EN
  always_ff @(posedge sys_clk) begin
    if (sys_rst) ptr_q <= '0;
    else         ptr_q <= ptr_d;
  end
`endif

  assign valid_down = valid_q;
  assign data_down  = data_q;
  assign src_down   = src_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// Self-checking bench for rr_arbiter (N_REQ=4, DATA_W=3), scoreboard-driven.
module tb_rr_arbiter;

  logic        sys_clk = 1'b0;
  logic        sys_rst;
  logic [3:0]  valid_up;
  logic [11:0] data_up;
  logic [3:0]  ready_up;
  logic        valid_down;
  logic [2:0]  data_down;
  logic [1:0]  src_down;
  logic        ready_down;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0] src;
    logic [2:0] data;
  } exp_t;
  exp_t sb[$];

  // Requester i offers word i+1.
  localparam logic [11:0] WORDS = {3'd4, 3'd3, 3'd2, 3'd1};

  rr_arbiter #(
    .N_REQ  (4),
    .DATA_W (3)
  ) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .valid_up   (valid_up),
    .data_up    (data_up),
    .ready_up   (ready_up),
    .valid_down (valid_down),
    .data_down  (data_down),
    .src_down   (src_down),
    .ready_down (ready_down)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic start(input logic [3:0] v);
    valid_up   = v;
    data_up    = WORDS;
    ready_down = 1'b1;
    sys_rst    = 1'b1;
    tick();
    sys_rst    = 1'b0;
  endtask

  task automatic test_reset();
    valid_up   = 4'b1111;
    data_up    = WORDS;
    ready_down = 1'b1;
    sys_rst    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      total++;
      if (ready_up !== 4'b0000) begin bad++; $display("FAIL reset_ready_up: got %b want 0000", ready_up); end
      total++;
      if (valid_down !== 1'b0) begin bad++; $display("FAIL reset_valid_down: got %b want 0", valid_down); end
    end
    sys_rst = 1'b0;
    #1;
    total++;
    if (ready_up !== 4'b0001) begin bad++; $display("FAIL release_ready_up: got %b want 0001", ready_up); end
    sb.push_back('{src: 2'd0, data: 3'd1});
    tick();
    begin
      exp_t e = sb.pop_front();
      total++;
      if (valid_down !== 1'b1 || src_down !== e.src || data_down !== e.data) begin
        bad++; $display("FAIL release_first_word: got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d",
                        valid_down, src_down, data_down, e.src, e.data);
      end
    end
  endtask

  task automatic test_rotation();
    start(4'b1111);
    for (int i = 0; i < 6; i++) begin
      sb.push_back('{src: 2'(i % 4), data: 3'((i % 4) + 1)});
      tick();
      begin
        exp_t e = sb.pop_front();
        total++;
        if (valid_down !== 1'b1 || src_down !== e.src || data_down !== e.data) begin
          bad++; $display("FAIL rotation[%0d]: got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d",
                          i, valid_down, src_down, data_down, e.src, e.data);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    start(4'b1111);
    tick();
    tick();
    ready_down = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++;
      if (valid_down !== 1'b1 || src_down !== 2'd1 || data_down !== 3'd2) begin
        bad++; $display("FAIL bp_hold[%0d]: got v=%b src=%0d data=%0d want v=1 src=1 data=2",
                        c, valid_down, src_down, data_down);
      end
      total++;
      if (ready_up !== 4'b0000) begin bad++; $display("FAIL bp_ready_up[%0d]: got %b want 0000", c, ready_up); end
      tick();
    end
    ready_down = 1'b1;
    #1;
    total++;
    if (ready_up !== 4'b0100) begin bad++; $display("FAIL bp_release_ready_up: got %b want 0100", ready_up); end
    sb.push_back('{src: 2'd2, data: 3'd3});
    tick();
    begin
      exp_t e = sb.pop_front();
      total++;
      if (valid_down !== 1'b1 || src_down !== e.src || data_down !== e.data) begin
        bad++; $display("FAIL bp_release_word: got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d",
                        valid_down, src_down, data_down, e.src, e.data);
      end
    end
  endtask

  task automatic test_wrap_sparse();
    logic [3:0] want_full;
    logic [1:0] want_src;
`ifdef RR_ARBITER_FIXED_PRIO_EN
    want_full = 4'b0001;
    want_src  = 2'd0;
`else
    want_full = 4'b1000;
    want_src  = 2'd3;
`endif
    start(4'b1111);
    tick();
    tick();
    tick();
    valid_up = 4'b0100;
    #1;
    total++;
    if (ready_up !== 4'b0100) begin bad++; $display("FAIL wrap_sparse_ready_up: got %b want 0100", ready_up); end
    sb.push_back('{src: 2'd2, data: 3'd3});
    tick();
    begin
      exp_t e = sb.pop_front();
      total++;
      if (valid_down !== 1'b1 || src_down !== e.src || data_down !== e.data) begin
        bad++; $display("FAIL wrap_sparse_word: got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d",
                        valid_down, src_down, data_down, e.src, e.data);
      end
    end
    valid_up = 4'b0000;
    #1;
    total++;
    if (ready_up !== 4'b0000) begin bad++; $display("FAIL idle_ready_up: got %b want 0000", ready_up); end
    tick();
    total++;
    if (valid_down !== 1'b0 || src_down !== 2'd2 || data_down !== 3'd3) begin
      bad++; $display("FAIL drain: got v=%b src=%0d data=%0d want v=0 src=2 data=3",
                      valid_down, src_down, data_down);
    end
    valid_up = 4'b1111;
    #1;
    total++;
    if (ready_up !== want_full) begin bad++; $display("FAIL ptr_held: got %b want %b", ready_up, want_full); end
    tick();
    total++;
    if (src_down !== want_src) begin bad++; $display("FAIL ptr_held_src: got %0d want %0d", src_down, want_src); end
    #1;
    total++;
    if (ready_up !== 4'b0001) begin bad++; $display("FAIL ptr_wrap: got %b want 0001", ready_up); end
  endtask

  task automatic test_fixed_prio();
    int g3 = 0;
    int want_g3;
    start(4'b1010);
    for (int c = 0; c < 8; c++) begin
      logic [3:0] want_rdy;
      exp_t e;
`ifdef RR_ARBITER_FIXED_PRIO_EN
      want_rdy = 4'b0010;
`else
      want_rdy = (c % 2 == 0) ? 4'b0010 : 4'b1000;
`endif
      #1;
      total++;
      if (ready_up !== want_rdy) begin bad++; $display("FAIL prio_ready_up[%0d]: got %b want %b", c, ready_up, want_rdy); end
      if (want_rdy == 4'b1000) sb.push_back('{src: 2'd3, data: 3'd4});
      else                     sb.push_back('{src: 2'd1, data: 3'd2});
      tick();
      e = sb.pop_front();
      if (src_down === 2'd3) g3++;
      total++;
      if (valid_down !== 1'b1 || src_down !== e.src || data_down !== e.data) begin
        bad++; $display("FAIL prio_word[%0d]: got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d",
                        c, valid_down, src_down, data_down, e.src, e.data);
      end
    end
`ifdef RR_ARBITER_FIXED_PRIO_EN
    want_g3 = 0;
`else
    want_g3 = 4;
`endif
    total++;
    if (g3 !== want_g3) begin bad++; $display("FAIL prio_req3_grants: got %0d want %0d", g3, want_g3); end
  endtask

  task automatic test_reset_mid();
    start(4'b1111);
    tick();
    tick();
    ready_down = 1'b0;
    sys_rst    = 1'b1;
    #1;
    total++;
    if (ready_up !== 4'b0000) begin bad++; $display("FAIL mid_reset_ready_up: got %b want 0000", ready_up); end
    tick();
    total++;
    if (valid_down !== 1'b0 || src_down !== 2'd0 || data_down !== 3'd0) begin
      bad++; $display("FAIL mid_reset_state: got v=%b src=%0d data=%0d want v=0 src=0 data=0",
                      valid_down, src_down, data_down);
    end
    sys_rst    = 1'b0;
    valid_up   = 4'b0110;
    ready_down = 1'b1;
    #1;
    total++;
    if (ready_up !== 4'b0010) begin bad++; $display("FAIL mid_reset_regrant: got %b want 0010", ready_up); end
    sb.push_back('{src: 2'd1, data: 3'd2});
    tick();
    begin
      exp_t e = sb.pop_front();
      total++;
      if (valid_down !== 1'b1 || src_down !== e.src || data_down !== e.data) begin
        bad++; $display("FAIL mid_reset_word: got v=%b src=%0d data=%0d want v=1 src=%0d data=%0d",
                        valid_down, src_down, data_down, e.src, e.data);
      end
    end
  endtask

  initial begin
    sys_rst    = 1'b1;
    valid_up   = '0;
    data_up    = '0;
    ready_down = 1'b0;
    test_reset();
    test_rotation();
    test_backpressure();
    test_wrap_sparse();
    test_fixed_prio();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Shares one downstream valid/ready channel between `N_REQ` upstream requesters. Each cycle it grants at most one requester in round-robin order and registers the winning word, plus its source index, into a single-entry output stage. That stage sustains one transfer per cycle under continuous `ready_down`. It sits in front of the depth-1 pipe stages of the bus-handshake datapath, so several producers can feed one pipe chain.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 3: payload width per requester.
- `sys_clk`  in  1  single clock; all logic on the rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `valid_up`  in  N_REQ  bit i set: requester i offers a word.
- `data_up`  in  N_REQ*DATA_W  flattened payloads; requester i occupies bits [i*DATA_W +: DATA_W].
- `ready_up`  out  N_REQ  one-hot or zero; bit i set: requester i's word is taken this edge.
- `valid_down`  out  1  output stage holds a word.
- `data_down`  out  DATA_W  held word.
- `src_down`  out  clog2(N_REQ)  index of the requester that supplied the held word.
- `ready_down`  in  1  downstream accepts the held word this edge.

## Operation
- Registered state:
  - Output stage: `valid_down`, `data_down`, `src_down`.
  - Round-robin pointer `ptr`, width clog2(N_REQ): the requester with highest priority.
- `can_load` = `!valid_down || ready_down`.
- Grant selection (combinational):
  - Scan `valid_up` starting at index `ptr`, moving upward, wrapping from N_REQ-1 to 0.
  - The first set bit wins.
- `ready_up[w]` = `can_load && valid_up[w]` for winner w. All other bits are 0.
- Transfer on the edge where `ready_up[w]`=1:
  - `valid_down` <= 1.
  - `data_down` <= payload w.
  - `src_down` <= w.
  - `ptr` <= (w+1) mod N_REQ.
- Drain without a new grant (`valid_down && ready_down` and no `valid_up` set):
  - `valid_down` <= 0.
  - `data_down` and `src_down` keep their last values.
- Otherwise all state holds.
- Requesters keep `valid_up` and data stable until granted. Withdrawal is undefined.

## Timing
- Reset values:
  - `valid_down`=0, `data_down`=0, `src_down`=0, `ptr`=0.
  - `ready_up`=0 in every cycle in which `sys_rst` is 1, regardless of other inputs.
- Latency: a word granted at edge k appears on `valid_down`/`data_down` after edge k; first observable in cycle k+1.
- Throughput: 1 word/cycle when `ready_down`=1 continuously. There is no bubble between different requesters.
- `ready_up` depends combinationally on `valid_up`, `ready_down`, `valid_down` and `ptr`. There is no path from `ready_up` back to any input.
- Full with `ready_down`=0:
  - `ready_up`=0.
  - `data_down` and `src_down` stay stable.
  - `ptr` is frozen.
- Simultaneous drain and grant: the stage reloads and `valid_down` stays 1. This is the required full-rate behaviour.
- No requests: `ptr` is unchanged.
- Pointer wrap: a winner of N_REQ-1 sets `ptr` to 0.
- Reset mid-operation: the held word is discarded, `valid_down` is 0 after the reset edge, and `ptr` returns to 0.

## Configuration
- Macro `RR_ARBITER_FIXED_PRIO_EN`.
- Defined: fixed priority.
  - The scan always starts at index 0, so the lowest set index wins.
  - `ptr` is not implemented.
  - Starvation of high indices is allowed and expected.
- Undefined (default): round-robin as described above.
- Handshake, latency and the output stage are identical in both modes.

## Structure
- Package `rr_arbiter_pkg` holds:
  - Defaults `ARB_N_REQ_DEF`=4 and `ARB_DATA_W_DEF`=3.
  - Function `arb_idx_w(n)`, returning clog2 with a minimum of 1.
- Sub-module `rr_pick`:
  - Inputs: `req`[N_REQ] and `ptr`.
  - Outputs: one-hot `gnt` and binary `gnt_idx`.
  - Purely combinational, using a double-width masked priority scan.
  - `rr_arbiter` instantiates it once and adds the output stage and pointer update.

## Test plan
All scenarios use N_REQ=4, DATA_W=3.

1. Reset hold: `sys_rst`=1 for 2 cycles with `valid_up`=1111 and `ready_down`=1.
   - During reset: `ready_up`=0000 and `valid_down`=0.
   - First cycle after release: `ready_up`=0001.
   - One cycle later: `src_down`=0.
2. Full-rate rotation: `valid_up`=1111 held, `data_up` word i = i+1, `ready_down`=1.
   - `src_down` runs 0,1,2,3,0,1 on consecutive cycles.
   - `data_down` runs 1,2,3,4,1,2.
   - `valid_down` never drops.
3. Backpressure: output holds src 1, data 2, and `ready_down`=0 for 3 cycles.
   - `data_down`=2 and `ready_up`=0000 throughout.
   - When `ready_down` returns to 1: `ready_up`=0100 in that same cycle, and next cycle `src_down`=2.
4. Wrap and sparse request: `ptr`=3, only `valid_up`=0100.
   - Requester 2 is granted.
   - `ptr` becomes 3.
   - Next cycle `valid_up`=0000 and `ready_down`=1: `valid_down` falls to 0 and `ptr` stays 3.
5. `RR_ARBITER_FIXED_PRIO_EN` defined, `valid_up`=1010 held, `ready_down`=1.
   - `src_down`=1 every cycle for 8 cycles.
   - Requester 3 is never granted.
6. Reset mid-operation: `valid_down`=1, `ready_down`=0, one-cycle `sys_rst` pulse.
   - After the edge: `valid_down`=0, `src_down`=0, `data_down`=0.
   - The next grant goes to the lowest valid index.
